// File: rtl/ifu_prefetch_pkg.sv
// Shared constants for the instruction prefetch unit.
package ifu_prefetch_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with a registered head entry; flush overrides push and pop.
module ifu_fifo
  import ifu_prefetch_pkg::*;
#(
  parameter int unsigned      WIDTH      = 64,
  parameter int unsigned      DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic                     head_valid_o,
  output logic [WIDTH-1:0]         head_data_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr_nxt;
  logic [LVL_W-1:0] count_q, count_d;
  logic             head_valid_q, head_valid_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop       = pop_i && head_valid_q;
    do_push      = push_i && ((count_q < LVL_W'(DEPTH)) || do_pop);
    rd_ptr_nxt   = rd_ptr_q + PTR_W'(1);
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    head_valid_d = head_valid_q;
    head_d       = head_q;
    if (flush_i) begin
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
      head_valid_d = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_nxt;
      count_d      = count_q + LVL_W'(do_push) - LVL_W'(do_pop);
      head_valid_d = (count_d != '0);
      // The pushed word becomes the head when the queue is (or is about to be) empty;
      // otherwise a pop promotes the next stored entry.
      if (do_push && ((count_q == '0) || ((count_q == LVL_W'(1)) && do_pop)))
        head_d = push_data_i;
      else if (do_pop && (count_q > LVL_W'(1)))
        head_d = mem_q[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_q       <= RESET_DATA;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush_i && do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_valid_o = head_valid_q;
  assign head_data_o  = head_q;
  assign level_o      = count_q;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: issues one fetch per cycle into a prefetch queue,
// discarding responses that belong to a stream squashed by a redirect.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    redirect_valid,
  input  logic [ADDR_W-1:0]       redirect_pc,
  output logic                    imem_req,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic [INSTR_W-1:0]      imem_rdata,
  input  logic                    imem_rvalid,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INSTR_W-1:0]      out_instr,
  output logic [ADDR_W-1:0]       out_pc,
  output logic [ADDR_W-1:0]       out_pc8,
  output logic [$clog2(DEPTH):0]  fifo_level
);

  localparam int unsigned LVL_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  pend_pc_q;
  logic               pend_valid_q, pend_epoch_q;
  logic               epoch_q, epoch_d;
  logic               issue, push, pop;
  logic               head_valid;
  logic [ENTRY_W-1:0] head_data;
  logic [LVL_W-1:0]   level;
  logic [LVL_W:0]     occupancy;

  // Space is reserved for the in-flight response; a same-cycle pop is not credited.
  assign occupancy = {1'b0, level} + (LVL_W+1)'(pend_valid_q);
  assign issue     = !reset && !redirect_valid && (occupancy < (LVL_W+1)'(DEPTH));
  assign push      = imem_rvalid && pend_valid_q && (pend_epoch_q == epoch_q);
  assign pop       = head_valid && out_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    epoch_d    = epoch_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & WORD_MASK;
      epoch_d    = !epoch_q;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC & WORD_MASK;
      epoch_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      pend_epoch_q <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      epoch_q      <= epoch_d;
      pend_valid_q <= issue;
      if (issue) begin
        pend_pc_q    <= fetch_pc_q;
        pend_epoch_q <= epoch_q;
      end
    end
  end

  ifu_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH      (DEPTH),
    .RESET_DATA ({{ADDR_W{1'b0}}, NOP_INSTR})
  ) u_fifo (
    .clk          (clk),
    .rst          (reset),
    .push_i       (push),
    .push_data_i  ({pend_pc_q, imem_rdata}),
    .pop_i        (pop),
    .flush_i      (redirect_valid),
    .head_valid_o (head_valid),
    .head_data_o  (head_data),
    .level_o      (level)
  );

  assign imem_req   = issue;
  assign imem_addr  = fetch_pc_q;
  assign out_valid  = head_valid;
  assign out_pc     = head_data[ENTRY_W-1:INSTR_W];
  assign out_instr  = head_data[INSTR_W-1:0];
  assign out_pc8    = head_valid ? (out_pc + ADDR_W'(8)) : '0;
  assign fifo_level = level;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: directed scenarios plus a randomized
// run against a transaction-level queue model.
module tb_ifu_prefetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_rvalid = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_pc, out_pc8;
  logic [2:0]  fifo_level;

  int n_chk  = 0;
  int n_fail = 0;
  bit spur_en = 1'b0;

  // Model: entries visible to decode, plus the one outstanding fetch.
  logic [31:0] mq[$];
  bit          m_pend;
  logic [31:0] m_pend_pc, m_fetch;

  ifu_prefetch #(
    .ADDR_W   (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_rvalid    (imem_rvalid),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc8        (out_pc8),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  function automatic bit exp_valid();
    return mq.size() != 0;
  endfunction

  function automatic logic [31:0] exp_pc();
    return (mq.size() != 0) ? mq[0] : 32'h0;
  endfunction

  function automatic logic [2:0] exp_level();
    return 3'(mq.size());
  endfunction

  function automatic bit exp_req();
    return !redirect_valid && ((mq.size() + (m_pend ? 1 : 0)) < int'(DEPTH));
  endfunction

  task automatic drive(input bit rd, input logic [31:0] rpc, input bit rdy);
    redirect_valid = rd;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
  endtask

  // Advance one clock; the memory answers each request one cycle later.
  task automatic tick();
    bit req, rd, rdy, rv, mreq;
    logic [31:0] addr, rpc;
    req = imem_req; addr = imem_addr; rd = redirect_valid; rpc = redirect_pc;
    rdy = out_ready; rv = imem_rvalid; mreq = exp_req();
    @(posedge clk);
    if (rd) begin
      mq.delete();
      m_fetch = rpc & 32'hFFFF_FFFC;
      m_pend  = 1'b0;
    end else begin
      if (rdy && mq.size() != 0) void'(mq.pop_front());
      if (m_pend && rv) mq.push_back(m_pend_pc);
      m_pend = mreq;
      if (mreq) begin
        m_pend_pc = m_fetch;
        m_fetch   = m_fetch + 32'd4;
      end
    end
    #1;
    imem_rvalid = req;
    imem_rdata  = memf(addr);
    if (!req && spur_en && $urandom_range(0, 3) == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
    end
    @(negedge clk);
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    #1;
    mq.delete();
    m_pend  = 1'b0;
    m_fetch = RESET_PC;
  endtask

  task automatic release_reset(input bit stale_rv);
    @(posedge clk);
    #1;
    imem_rvalid = stale_rv;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    assert_reset();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    n_chk++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rst_level got=%0d exp=0", fifo_level); end
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    n_chk++; if (out_pc !== 32'h0 || out_instr !== 32'h0 || out_pc8 !== 32'h0) begin
      n_fail++; $display("FAIL rst_data got pc=%h instr=%h pc8=%h exp all 0", out_pc, out_instr, out_pc8); end
    release_reset(1'b0);
    for (int c = 0; c < 14; c++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * c)) begin
        n_fail++; $display("FAIL stream_req c=%0d got req=%b addr=%h exp 1/%h", c, imem_req, imem_addr, 32'(4 * c)); end
      n_chk++; if (out_valid !== (c >= 2)) begin
        n_fail++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, out_valid, (c >= 2)); end
      if (c >= 2) begin
        e = 32'(4 * (c - 2));
        n_chk++; if (out_pc !== e || out_instr !== memf(e) || out_pc8 !== e + 32'd8) begin
          n_fail++; $display("FAIL stream_data c=%0d got pc=%h instr=%h pc8=%h exp %h/%h/%h",
                             c, out_pc, out_instr, out_pc8, e, memf(e), e + 32'd8); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    int nreq = 0;
    assert_reset();
    release_reset(1'b0);
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 32'h0, 1'b0);
      if (imem_req) begin
        n_chk++; if (imem_addr !== 32'(4 * nreq)) begin
          n_fail++; $display("FAIL stall_addr got=%h exp=%h", imem_addr, 32'(4 * nreq)); end
        nreq++;
      end
      if (c >= 2) begin
        n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
          n_fail++; $display("FAIL stall_hold c=%0d got valid=%b pc=%h exp 1/0", c, out_valid, out_pc); end
      end
      tick();
    end
    drive(1'b0, 32'h0, 1'b0);
    n_chk++; if (nreq != int'(DEPTH)) begin n_fail++; $display("FAIL stall_nreq got=%0d exp=%0d", nreq, DEPTH); end
    n_chk++; if (fifo_level !== 3'(DEPTH)) begin n_fail++; $display("FAIL stall_level got=%0d exp=%0d", fifo_level, DEPTH); end
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req got=%b exp=0", imem_req); end
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * k)) begin
        n_fail++; $display("FAIL drain k=%0d got valid=%b pc=%h exp 1/%h", k, out_valid, out_pc, 32'(4 * k)); end
      tick();
    end
  endtask

  task automatic test_redirect();
    assert_reset();
    release_reset(1'b0);
    for (int c = 0; c < 3; c++) begin drive(1'b0, 32'h0, 1'b0); tick(); end
    drive(1'b0, 32'h0, 1'b0);
    n_chk++; if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL redir_pre_level got=%0d exp=2", fifo_level); end
    drive(1'b1, 32'h0000_0103, 1'b1);
    n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_req_R got=%b exp=0", imem_req); end
    tick();
    drive(1'b0, 32'h0, 1'b1);
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++; $display("FAIL redir_addr got req=%b addr=%h exp 1/00000100", imem_req, imem_addr); end
    n_chk++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL redir_flush got valid=%b level=%0d exp 0/0", out_valid, fifo_level); end
    tick();
    drive(1'b0, 32'h0, 1'b1);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_r2_valid got=%b exp=0", out_valid); end
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4 * k)) begin
        n_fail++; $display("FAIL redir_stream k=%0d got valid=%b pc=%h exp 1/%h", k, out_valid, out_pc, 32'h100 + 32'(4 * k)); end
      tick();
    end
  endtask

  task automatic test_double_redirect();
    for (int c = 0; c < 3; c++) begin drive(1'b0, 32'h0, 1'b1); tick(); end
    drive(1'b1, 32'h0000_0200, 1'b1); tick();
    drive(1'b1, 32'h0000_0300, 1'b1); tick();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      if (k == 0) begin
        n_chk++; if (imem_addr !== 32'h300) begin n_fail++; $display("FAIL dbl_addr got=%h exp=00000300", imem_addr); end
      end
      n_chk++; if (out_valid !== (k >= 2)) begin n_fail++; $display("FAIL dbl_valid k=%0d got=%b exp=%b", k, out_valid, (k >= 2)); end
      if (k >= 2) begin
        n_chk++; if (out_pc !== 32'h300 + 32'(4 * (k - 2))) begin
          n_fail++; $display("FAIL dbl_pc k=%0d got=%h exp=%h", k, out_pc, 32'h300 + 32'(4 * (k - 2))); end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    drive(1'b1, 32'hFFFF_FFF8, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b1); tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 1'b1);
      e = 32'hFFFF_FFF8 + 32'(4 * k);
      n_chk++; if (out_valid !== 1'b1 || out_pc !== e || out_instr !== memf(e)) begin
        n_fail++; $display("FAIL wrap_pc k=%0d got valid=%b pc=%h instr=%h exp 1/%h/%h", k, out_valid, out_pc, out_instr, e, memf(e)); end
      n_chk++; if (out_pc8 !== e + 32'd8) begin
        n_fail++; $display("FAIL wrap_pc8 k=%0d got=%h exp=%h", k, out_pc8, e + 32'd8); end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    assert_reset();
    release_reset(1'b0);
    for (int c = 0; c < 4; c++) begin drive(1'b0, 32'h0, 1'b0); tick(); end
    drive(1'b0, 32'h0, 1'b0);
    n_chk++; if (fifo_level !== 3'd3 || imem_req !== 1'b0) begin
      n_fail++; $display("FAIL mid_full got level=%0d req=%b exp 3/0", fifo_level, imem_req); end
    #2;
    assert_reset();
    n_chk++; if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      n_fail++; $display("FAIL mid_async got valid=%b level=%0d exp 0/0", out_valid, fifo_level); end
    release_reset(1'b1);
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_chk++; if (out_valid !== (c >= 2)) begin n_fail++; $display("FAIL mid_valid c=%0d got=%b exp=%b", c, out_valid, (c >= 2)); end
      if (c >= 2) begin
        n_chk++; if (out_pc !== 32'(4 * (c - 2))) begin
          n_fail++; $display("FAIL mid_pc c=%0d got=%h exp=%h", c, out_pc, 32'(4 * (c - 2))); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit rd;
    logic [31:0] rpc;
    assert_reset();
    release_reset(1'b0);
    spur_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      rd  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive(rd, rpc, $urandom_range(0, 3) != 0);
      n_chk++; if (out_valid !== exp_valid()) begin
        n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, exp_valid()); end
      if (exp_valid()) begin
        n_chk++; if (out_pc !== exp_pc() || out_instr !== memf(exp_pc()) || out_pc8 !== exp_pc() + 32'd8) begin
          n_fail++; $display("FAIL rnd_data c=%0d got pc=%h instr=%h pc8=%h exp %h/%h/%h",
                             c, out_pc, out_instr, out_pc8, exp_pc(), memf(exp_pc()), exp_pc() + 32'd8); end
      end
      n_chk++; if (fifo_level !== exp_level()) begin
        n_fail++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, fifo_level, exp_level()); end
      n_chk++; if (imem_req !== exp_req()) begin
        n_fail++; $display("FAIL rnd_req c=%0d got=%b exp=%b", c, imem_req, exp_req()); end
      if (exp_req()) begin
        n_chk++; if (imem_addr !== m_fetch) begin
          n_fail++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, imem_addr, m_fetch); end
      end
      tick();
    end
    spur_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_stall();
    test_redirect();
    test_double_redirect();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
